smvm_row_collector: RTL and testbench
=====================================

# smvm_row_collector

Downstream stage of the SMVM core. Captures the row results the core emits on `out_valid`/`data_out`, which have no back-pressure and arrive in variable-length bursts. Each result is tagged with its row index and buffered in a FIFO, then presented to the consumer on a valid/ready interface with end-of-matrix marking and completion signalling. The block absorbs the core's burst output so a slower consumer (bus master, output serializer) never loses results, and flags any loss that does occur.

## Interface
- `DATA_W`, 13: result width; matches the SMVM `data_out` width.
- `ROW_W`, 9: row index width; maximum matrix size is 511 rows.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 8.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a matrix; sampled only in IDLE.
- `num_rows`  in  ROW_W  expected result count; sampled with `start`.
- `in_valid`  in  1  result strobe; connects to SMVM `out_valid`.
- `in_data`  in  DATA_W  result value; connects to SMVM `data_out`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  DATA_W  head result.
- `out_row`  out  ROW_W  row index of the head result.
- `out_last`  out  1  head entry is row `num_rows-1`.
- `busy`  out  1  high in COLLECT and DRAIN.
- `done`  out  1  one-cycle pulse when the final row is popped.
- `overflow`  out  1  sticky; a result was dropped. Cleared only by `start` or `rst`.

## Operation
- **States:** IDLE, COLLECT, DRAIN. A 2-bit register, encoded in `smvm_pkg`.
- **IDLE:**
  - `in_valid` is ignored.
  - On `start` with `num_rows` > 0: latch `num_rows`, clear `wr_row`, `rd_row` and `overflow`, go to COLLECT.
  - On `start` with `num_rows` == 0: pulse `done` on the next cycle and stay in IDLE.
- **COLLECT:**
  - Push: `in_valid` && !full && `wr_row` < `num_rows` writes {`wr_row`, `in_data`} and increments `wr_row`.
  - `in_valid` && full: the result is dropped, `overflow` is set, and `wr_row` still increments. Row numbering stays aligned with the core's output order.
  - When `wr_row` reaches `num_rows`, go to DRAIN.
- **DRAIN:**
  - Pushes are disabled.
  - Any further `in_valid` sets `overflow`; the data is discarded.
- **Pop (COLLECT or DRAIN):** on `out_valid` && `out_ready`.
  - The FIFO is first-word-fall-through: `out_data`, `out_row` and `out_last` reflect the head entry whenever `out_valid` is high.
- **Completion:** popping the entry whose row is `num_rows-1` pulses `done` on the following cycle and returns the block to IDLE.
  - If that row was dropped, `done` fires instead when `wr_row` == `num_rows` and the FIFO is empty.
- **Full/empty:** derived from a registered occupancy count (0..DEPTH). Full is evaluated before the same-cycle pop, so a push into a full FIFO is rejected even if a pop happens in the same cycle.
- **Simultaneous push and pop (not full):** both take effect and the count is unchanged.
- **Counter width:** `wr_row` and `rd_row` are ROW_W bits and never wrap, because `num_rows` ≤ 511. FIFO pointers wrap modulo DEPTH.
- **`start` while busy:** ignored.

## Timing
- **Reset values:**
  - All outputs are 0: `out_valid`, `out_data`, `out_row`, `out_last`, `busy`, `done`, `overflow`.
  - State is IDLE and the FIFO is empty.
- **Reset mid-operation:** the FIFO is flushed and the current matrix is abandoned; `done` is not pulsed.
- **Latency:**
  - `in_valid` at cycle N → `out_valid` at N+1 when the FIFO was empty.
  - `busy` rises the cycle after `start`.
- **Throughput:** one push and one pop per cycle. A burst of up to DEPTH consecutive results is lossless with `out_ready` held low.
- **Handshake:** `out_valid`, `out_data` and `out_row` hold stable until accepted. `out_valid` never depends combinationally on `out_ready`.

## Structure
- **Package `smvm_pkg`:**
  - DATA_W and ROW_W defaults, shared with SMVM.
  - State encoding constants: IDLE=0, COLLECT=1, DRAIN=2.
  - FIFO entry width, ROW_W+DATA_W (22 bits).
- **Sub-module `smvm_sync_fifo`:**
  - Parameterized width and depth, FWFT, count output, push/pop/full/empty.
  - The collector adds the FSM, row counters, `overflow` and `done`.

## Test plan
- **Basic:** `start`, `num_rows`=4; 4 results 0x10,0x11,0x12,0x13, `out_ready`=1 → rows 0..3 in order, `out_last` on row 3, `done` one cycle after the 4th pop, `overflow`=0.
- **Back-pressure:** `num_rows`=16; 16 back-to-back results with `out_ready`=0 → no loss. Release `out_ready` → 16 pops in order, `done`.
- **Overflow:** DEPTH=16, `num_rows`=20; 20 consecutive results with `out_ready`=0 → rows 16..19 dropped, `overflow`=1. Draining yields rows 0..15, then `done` once empty.
- **Zero rows:** `start` with `num_rows`=0 → `done` next cycle, `busy` never asserted.
- **Stray input:** `in_valid` in IDLE, and an extra result in DRAIN → nothing enqueued; `overflow` is set only for the DRAIN case.
- **Reset mid-run:** assert `rst` with 5 entries queued → all outputs 0 immediately, no `done`. A new `start` works normally.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared definitions for the SMVM core and its downstream stages:
// default widths, collector state encoding and FIFO entry width.
package smvm_pkg;

    localparam int SMVM_DATA_W  = 13;
    localparam int SMVM_ROW_W   = 9;
    localparam int SMVM_ENTRY_W = SMVM_ROW_W + SMVM_DATA_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/smvm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on rd_data whenever empty is low; push into
// a full FIFO and pop from an empty FIFO are ignored.
module smvm_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap modulo DEPTH; count tracks occupancy so full/empty are unambiguous
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array is not reset; only the pointers define its contents
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/smvm_row_collector.sv
// Collects the SMVM core's row results, which arrive without back-pressure,
// tags each with its row index, buffers them and hands them to a consumer
// over valid/ready with end-of-matrix marking, completion pulse and a sticky
// loss flag.
module smvm_row_collector
    import smvm_pkg::*;
#(
    parameter int DATA_W = SMVM_DATA_W,
    parameter int ROW_W  = SMVM_ROW_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int ENTRY_W = ROW_W + DATA_W;

    logic [1:0]            state;
    logic [ROW_W-1:0]      num_rows_q;
    logic [ROW_W-1:0]      wr_row;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]    fifo_wr_data;
    logic [ENTRY_W-1:0]    fifo_rd_data;

    logic                  accept;
    logic                  head_is_last;
    logic                  last_pop;
    logic                  drain_empty;
    logic [ROW_W-1:0]      head_row;
    logic [DATA_W-1:0]     head_data;

    assign accept       = (state == ST_COLLECT) && in_valid && (wr_row < num_rows_q);
    assign fifo_push    = accept && !fifo_full;
    assign fifo_wr_data = {wr_row, in_data};
    assign {head_row, head_data} = fifo_rd_data;

    assign out_valid    = (state != ST_IDLE) && !fifo_empty;
    assign fifo_pop     = out_valid && out_ready;
    assign out_data     = out_valid ? head_data : '0;
    assign out_row      = out_valid ? head_row  : '0;
    assign head_is_last = (head_row == num_rows_q - ROW_W'(1));
    assign out_last     = out_valid && head_is_last;
    assign last_pop     = fifo_pop && head_is_last;
    assign drain_empty  = (state == ST_DRAIN) && (fifo_count == '0) && (wr_row == num_rows_q);
    assign busy         = (state != ST_IDLE);

    smvm_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Matrix sequencing: row numbering, loss detection and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            num_rows_q <= '0;
            wr_row     <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        overflow <= 1'b0;
                        if (num_rows != '0) begin
                            num_rows_q <= num_rows;
                            wr_row     <= '0;
                            state      <= ST_COLLECT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        wr_row <= wr_row + ROW_W'(1);
                        if (fifo_full)
                            overflow <= 1'b1;
                        if (wr_row + ROW_W'(1) == num_rows_q)
                            state <= ST_DRAIN;
                    end
                    if (last_pop) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (in_valid)
                        overflow <= 1'b1;
                    if (last_pop || drain_empty) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smvm_row_collector.sv
// Directed bench for the row collector: a vector table for the basic flow,
// zero-row start and stray input in IDLE, then hand-written sequences for
// back-pressure, overflow, stray input in DRAIN and reset mid-run.
module tb_smvm_row_collector;

    localparam int DATA_W = 13;
    localparam int ROW_W  = 9;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ROW_W-1:0]  num_rows;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overflow;

    int passCount;
    int checkCount;

    typedef struct packed {
        logic              start;
        logic [ROW_W-1:0]  num_rows;
        logic              in_valid;
        logic [DATA_W-1:0] in_data;
        logic              out_ready;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic [ROW_W-1:0]  exp_row;
        logic              exp_last;
        logic              exp_busy;
        logic              exp_done;
        logic              exp_ov;
    } vec_t;

    vec_t vecs [11];

    smvm_row_collector #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then land just after the consuming edge
    task automatic applyStimulus(input logic s, input logic [ROW_W-1:0] n, input logic iv,
                                 input logic [DATA_W-1:0] d, input logic rdy);
        start     = s;
        num_rows  = n;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values
    task automatic checkOutput(input string name, input logic ev, input logic [DATA_W-1:0] ed,
                               input logic [ROW_W-1:0] er, input logic el, input logic eb,
                               input logic edn, input logic eov);
        logic [DATA_W+ROW_W+4:0] act;
        logic [DATA_W+ROW_W+4:0] exp;
        act = {out_valid, out_data, out_row, out_last, busy, done, overflow};
        exp = {ev, ed, er, el, eb, edn, eov};
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got valid=%b data=%h row=%0d last=%b busy=%b done=%b ovf=%b, want valid=%b data=%h row=%0d last=%b busy=%b done=%b ovf=%b",
                     name, out_valid, out_data, out_row, out_last, busy, done, overflow,
                     ev, ed, er, el, eb, edn, eov);
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        //          start n   iv  data      rdy | v  data      row  last busy done ov
        vecs[0]  = '{1'b1, 9'd4, 1'b0, 13'h000, 1'b1, 1'b0, 13'h000, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 9'd0, 1'b1, 13'h010, 1'b1, 1'b1, 13'h010, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 9'd0, 1'b1, 13'h011, 1'b1, 1'b1, 13'h011, 9'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 9'd0, 1'b1, 13'h012, 1'b1, 1'b1, 13'h012, 9'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 9'd0, 1'b1, 13'h013, 1'b1, 1'b1, 13'h013, 9'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 9'd0, 1'b0, 13'h000, 1'b1, 1'b0, 13'h000, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 9'd0, 1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 9'd0, 1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 9'd0, 1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 9'd0, 1'b1, 13'h055, 1'b0, 1'b0, 13'h000, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 9'd0, 1'b0, 13'h000, 1'b1, 1'b0, 13'h000, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("reset_state", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: basic 4-row matrix, zero-row start, stray input in IDLE
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].start, vecs[i].num_rows, vecs[i].in_valid,
                          vecs[i].in_data, vecs[i].out_ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                        vecs[i].exp_row, vecs[i].exp_last, vecs[i].exp_busy,
                        vecs[i].exp_done, vecs[i].exp_ov);
        end

        // Back-pressure: 16 results with out_ready low, then drain
        applyStimulus(1'b1, 9'd16, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b0, 9'd0, 1'b1, 13'h100 + 13'(i), 1'b0);
        checkOutput("bp_full", 1'b1, 13'h100, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("bp_pop%0d", i), 1'b1, 13'h100 + 13'(i), 9'(i),
                        (i == 15), 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        end
        checkOutput("bp_done", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b0);
        checkOutput("bp_after", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Overflow: 20 results into a 16-deep FIFO, rows 16..19 lost
        applyStimulus(1'b1, 9'd20, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 9'd0, 1'b1, 13'h200 + 13'(i), 1'b0);
        checkOutput("ov_flag", 1'b1, 13'h200, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("ov_pop%0d", i), 1'b1, 13'h200 + 13'(i), 9'(i),
                        1'b0, 1'b1, 1'b0, 1'b1);
            applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        end
        checkOutput("ov_empty", 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        checkOutput("ov_done", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b0);
        checkOutput("ov_sticky", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stray result in DRAIN: flagged, never enqueued; start clears overflow
        applyStimulus(1'b1, 9'd2, 1'b0, '0, 1'b0);
        checkOutput("stray_start", 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 13'h0A0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 13'h0A1, 1'b0);
        checkOutput("stray_two", 1'b1, 13'h0A0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 13'h0A2, 1'b0);
        checkOutput("stray_ovf", 1'b1, 13'h0A0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        checkOutput("stray_row1", 1'b1, 13'h0A1, 9'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        checkOutput("stray_done", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-run with 5 entries queued
        applyStimulus(1'b1, 9'd8, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 9'd0, 1'b1, 13'h300 + 13'(i), 1'b0);
        checkOutput("rst_queued", 1'b1, 13'h300, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
            checkOutput($sformatf("rst_quiet%0d", i), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 9'd1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1, 13'h3AB, 1'b0);
        checkOutput("rst_restart", 1'b1, 13'h3AB, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, '0, 1'b1);
        checkOutput("rst_redone", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
